// File: rtl/game_pkg.sv
// Shared definitions for the turn controller: FSM states, tile geometry
// matching the renderer's layout, and the tile-to-pixel conversion.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MOVE,
    ST_WAIT,
    ST_CHECK,
    ST_OVER
  } state_t;

  // Tile geometry shared with the renderer.
  localparam int unsigned TILE_X0    = 20;
  localparam int unsigned TILE_PITCH = 60;

  // Tile index width (tiles 0..10), one extra bit for the unclamped sum,
  // and the pixel coordinate width.
  localparam int unsigned TILE_W = 4;
  localparam int unsigned SUM_W  = TILE_W + 1;
  localparam int unsigned X_W    = 10;

  // x = x0 + tile * pitch, truncated to the pixel bus width.
  function automatic logic [X_W-1:0] tile_to_x(
    input logic [TILE_W-1:0] tile,
    input int unsigned       x0,
    input int unsigned       pitch
  );
    int unsigned x;
    x = x0 + (int'(unsigned'(tile)) * pitch);
    return X_W'(x);
  endfunction

endpackage

// File: rtl/turn_timeout_counter.sv
// Watchdog for the renderer handshake: counts enabled cycles since the last
// clear and flags when DONE_TIMEOUT cycles of waiting have been spent.
module turn_timeout_counter #(
  parameter int unsigned DONE_TIMEOUT = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int unsigned CNT_W = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DONE_TIMEOUT - 1);

  logic [CNT_W-1:0] r_count;

  // Count enabled cycles; clear wins, and the count parks at its last value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != CNT_LAST)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = (r_count == CNT_LAST);

endmodule

// File: rtl/game_turn_controller.sv
// Game-logic master for the renderer position interface: turns dice rolls
// into tile positions, waits for the renderer's turn_done, applies the
// question-box bonus and detects the finish tile.
module game_turn_controller
  import game_pkg::*;
#(
  parameter int unsigned TILE_X0      = game_pkg::TILE_X0,
  parameter int unsigned TILE_PITCH   = game_pkg::TILE_PITCH,
  parameter int unsigned LAST_TILE    = 10,
  parameter int unsigned QBOX_TILE    = 3,
  parameter int unsigned QBOX_BONUS   = 2,
  parameter int unsigned DONE_TIMEOUT = 4096
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           roll_valid,
  input  logic [2:0]     roll_value,
  output logic           roll_ready,
  input  logic           turn_done,
  output logic [X_W-1:0] player1_pos_x,
  output logic [X_W-1:0] player2_pos_x,
  output logic           pos_valid,
  output logic           active_player,
  output logic           game_over,
  output logic           winner,
  output logic           timeout_err
);

  state_t            r_state;
  state_t            w_next_state;

  logic [TILE_W-1:0] r_tile1;
  logic [TILE_W-1:0] r_tile2;
  logic [X_W-1:0]    r_p1_x;
  logic [X_W-1:0]    r_p2_x;
  logic              r_active;
  logic              r_bonus_used;
  logic              r_timeout_err;

  logic [TILE_W-1:0] w_cur_tile;
  logic [SUM_W-1:0]  w_sum;
  logic [TILE_W-1:0] w_new_tile;
  logic [2:0]        w_step;
  logic              w_roll_ok;
  logic              w_load_move;
  logic              w_toggle;
  logic              w_set_bonus;
  logic              w_set_timeout;
  logic              w_cnt_clr;
  logic              w_cnt_en;
  logic              w_expired;

  // Tile of whichever player currently owns the turn.
  assign w_cur_tile = r_active ? r_tile2 : r_tile1;

  // Advance by the step in the wider sum so it cannot wrap, then clamp.
  assign w_sum      = SUM_W'(w_cur_tile) + SUM_W'(w_step);
  assign w_new_tile = (w_sum >= SUM_W'(LAST_TILE)) ? TILE_W'(LAST_TILE)
                                                   : w_sum[TILE_W-1:0];

  assign w_roll_ok  = roll_valid && (roll_value != 3'd0) && (roll_value != 3'd7);

  turn_timeout_counter #(
    .DONE_TIMEOUT(DONE_TIMEOUT)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_cnt_clr),
    .i_en     (w_cnt_en),
    .o_expired(w_expired)
  );

  // FSM state register.
  // NOTE: every clocked block uses non-blocking (<=) so all registers see
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic and the per-cycle control strobes for the datapath.
  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_state  = r_state;
    w_step        = 3'd0;
    w_load_move   = 1'b0;
    w_toggle      = 1'b0;
    w_set_bonus   = 1'b0;
    w_set_timeout = 1'b0;
    w_cnt_clr     = 1'b0;
    w_cnt_en      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_roll_ok) begin
          w_step       = roll_value;
          w_load_move  = 1'b1;
          w_next_state = ST_MOVE;
        end
      end
      ST_MOVE: begin
        w_cnt_clr    = 1'b1;
        w_next_state = ST_WAIT;
      end
      ST_WAIT: begin
        w_cnt_en = 1'b1;
        if (turn_done) begin
          w_next_state = ST_CHECK;
        end else if (w_expired) begin
          w_set_timeout = 1'b1;
          w_next_state  = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (w_cur_tile == TILE_W'(LAST_TILE)) begin
          w_next_state = ST_OVER;
        end else if ((w_cur_tile == TILE_W'(QBOX_TILE)) && !r_bonus_used) begin
          w_set_bonus  = 1'b1;
          w_step       = 3'(QBOX_BONUS);
          w_load_move  = 1'b1;
          w_next_state = ST_MOVE;
        end else begin
          w_toggle     = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
      ST_OVER: begin
        w_next_state = ST_OVER;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Player tiles and pixel positions; loaded on the edge entering MOVE so
  // the new position is already on the bus while pos_valid is high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tile1 <= '0;
      r_tile2 <= '0;
      r_p1_x  <= tile_to_x('0, TILE_X0, TILE_PITCH);
      r_p2_x  <= tile_to_x('0, TILE_X0, TILE_PITCH);
    end else if (w_load_move) begin
      if (r_active) begin
        r_tile2 <= w_new_tile;
        r_p2_x  <= tile_to_x(w_new_tile, TILE_X0, TILE_PITCH);
      end else begin
        r_tile1 <= w_new_tile;
        r_p1_x  <= tile_to_x(w_new_tile, TILE_X0, TILE_PITCH);
      end
    end
  end

  // Turn ownership, one-bonus-per-turn flag and the sticky timeout flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_active      <= 1'b0;
      r_bonus_used  <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_toggle) begin
        r_active     <= ~r_active;
        r_bonus_used <= 1'b0;
      end else if (w_set_bonus) begin
        r_bonus_used <= 1'b1;
      end
      if (w_set_timeout) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign roll_ready    = (r_state == ST_IDLE);
  assign pos_valid     = (r_state == ST_MOVE);
  assign game_over     = (r_state == ST_OVER);
  assign winner        = game_over & r_active;
  assign active_player = r_active;
  assign player1_pos_x = r_p1_x;
  assign player2_pos_x = r_p2_x;
  assign timeout_err   = r_timeout_err;

endmodule

// File: tb/tb_game_turn_controller.sv
// Self-checking bench for game_turn_controller: a tile model predicts every
// position pulse into a queue, and a negedge monitor pops and compares.
module tb_game_turn_controller;

  logic       clk;
  logic       rst;
  logic       roll_valid;
  logic [2:0] roll_value;
  logic       roll_ready;
  logic       turn_done;
  logic [9:0] player1_pos_x;
  logic [9:0] player2_pos_x;
  logic       pos_valid;
  logic       active_player;
  logic       game_over;
  logic       winner;
  logic       timeout_err;

  game_turn_controller #(
    .DONE_TIMEOUT(16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .roll_valid   (roll_valid),
    .roll_value   (roll_value),
    .roll_ready   (roll_ready),
    .turn_done    (turn_done),
    .player1_pos_x(player1_pos_x),
    .player2_pos_x(player2_pos_x),
    .pos_valid    (pos_valid),
    .active_player(active_player),
    .game_over    (game_over),
    .winner       (winner),
    .timeout_err  (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       player;
    logic [9:0] p1x;
    logic [9:0] p2x;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   pulses_seen = 0;
  int   pulses_exp  = 0;
  int   m_tile[2];
  logic m_active;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic logic [9:0] model_x(input int t);
    return 10'(20 + 60 * t);
  endfunction

  function automatic int clamp_tile(input int t);
    return (t > 10) ? 10 : t;
  endfunction

  task automatic push_exp();
    exp_t e;
    e.player = m_active;
    e.p1x    = model_x(m_tile[0]);
    e.p2x    = model_x(m_tile[1]);
    sb_q.push_back(e);
    pulses_exp++;
  endtask

  // Pops one expectation per position pulse.
  always @(negedge clk) begin
    if (rst && pos_valid) begin
      exp_t e;
      pulses_seen++;
      check("pulse_expected", 32'(sb_q.size() > 0), 1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("pulse_p1x", player1_pos_x, e.p1x);
        check("pulse_p2x", player2_pos_x, e.p2x);
        check("pulse_player", active_player, e.player);
      end
    end
  end

  // Caller sits at posedge+1; returns at posedge+1 one cycle later.
  task automatic drive_roll(input logic [2:0] v);
    roll_valid = 1'b1;
    roll_value = v;
    @(posedge clk); #1;
    roll_valid = 1'b0;
    roll_value = 3'd0;
  endtask

  task automatic pulse_done();
    turn_done = 1'b1;
    @(posedge clk); #1;
    turn_done = 1'b0;
  endtask

  // Full turn with model update; poke drives a stray roll while in WAIT.
  task automatic take_turn(input logic [2:0] v, input bit poke);
    int  p;
    int  moves;
    bit  over;
    p = int'(m_active);
    m_tile[p] = clamp_tile(m_tile[p] + int'(v));
    push_exp();
    moves = 1;
    if (m_tile[p] == 3) begin
      m_tile[p] = clamp_tile(m_tile[p] + 2);
      push_exp();
      moves = 2;
    end
    over = (m_tile[p] == 10);
    drive_roll(v);
    for (int k = 0; k < moves; k++) begin
      @(posedge clk); #1;
      if (poke && k == 0) drive_roll(3'd5);
      pulse_done();
      check("active_hold_check", active_player, m_active);
      @(posedge clk); #1;
    end
    if (over) begin
      check("game_over", game_over, 1);
      check("winner", winner, m_active);
      check("active_frozen", active_player, m_active);
    end else begin
      m_active = ~m_active;
      check("active_toggle", active_player, m_active);
      check("ready_after_turn", roll_ready, 1);
    end
    check("pulse_count", pulses_seen, pulses_exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst        = 1'b0;
    roll_valid = 1'b0;
    roll_value = 3'd0;
    turn_done  = 1'b0;
    m_tile[0]  = 0;
    m_tile[1]  = 0;
    m_active   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    check("rst_ready", roll_ready, 1);
    check("rst_p1x", player1_pos_x, 20);
    check("rst_p2x", player2_pos_x, 20);
    check("rst_pos_valid", pos_valid, 0);
    check("rst_active", active_player, 0);
    check("rst_game_over", game_over, 0);
    check("rst_winner", winner, 0);
    check("rst_timeout", timeout_err, 0);

    // P1 rolls 4 -> tile 4, x 260.
    take_turn(3'd4, 1'b0);
    // P2 rolls 3 -> qbox, bonus to tile 5.
    take_turn(3'd3, 1'b0);

    // Illegal roll values and a stray turn_done in IDLE.
    drive_roll(3'd0);
    check("ready_after_roll0", roll_ready, 1);
    drive_roll(3'd7);
    check("ready_after_roll7", roll_ready, 1);
    pulse_done();
    @(posedge clk); #1;
    check("idle_done_active", active_player, m_active);
    check("idle_done_ready", roll_ready, 1);
    check("invalid_pulse_count", pulses_seen, pulses_exp);

    // P1 rolls 2 -> tile 6, with a stray roll during WAIT.
    take_turn(3'd2, 1'b1);

    // P2 rolls 3 -> tile 8, turn_done withheld: 16 WAIT cycles then timeout.
    m_tile[1] = clamp_tile(m_tile[1] + 3);
    push_exp();
    drive_roll(3'd3);
    n = 0;
    while (!timeout_err && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("timeout_edges", n, 17);
    check("timeout_flag", timeout_err, 1);
    @(posedge clk); #1;
    m_active = ~m_active;
    check("timeout_advance", active_player, m_active);
    check("timeout_ready", roll_ready, 1);

    // P1 rolls 3 -> tile 9; timeout flag stays set.
    take_turn(3'd3, 1'b0);
    check("timeout_sticky", timeout_err, 1);

    // P2 at tile 8 rolls 6 -> clamped to tile 10, game over.
    take_turn(3'd6, 1'b0);
    drive_roll(3'd4);
    pulse_done();
    repeat (3) @(posedge clk);
    #1;
    check("over_pulse_count", pulses_seen, pulses_exp);
    check("over_ready", roll_ready, 0);
    check("over_sticky", game_over, 1);
    check("over_active", active_player, 1);

    // Fresh game, reset asserted while waiting for turn_done.
    rst = 1'b0;
    #1;
    rst = 1'b1;
    m_tile[0] = 0;
    m_tile[1] = 0;
    m_active  = 1'b0;
    @(posedge clk); #1;
    m_tile[0] = 5;
    push_exp();
    drive_roll(3'd5);
    @(posedge clk); #1;
    check("pre_rst_wait", roll_ready, 0);
    #2;
    rst = 1'b0;
    #1;
    check("arst_ready", roll_ready, 1);
    check("arst_p1x", player1_pos_x, 20);
    check("arst_p2x", player2_pos_x, 20);
    check("arst_pos_valid", pos_valid, 0);
    check("arst_active", active_player, 0);
    check("arst_game_over", game_over, 0);
    check("arst_timeout", timeout_err, 0);
    m_tile[0] = 0;
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    pulse_done();
    @(posedge clk); #1;
    check("late_done_active", active_player, 0);
    check("late_done_ready", roll_ready, 1);

    // P1 rolls 2 -> tile 2, x 140.
    take_turn(3'd2, 1'b0);
    check("queue_drained", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
